// File: rtl/sram_bank_arb.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank_arb
// Description : Dual-port, multi-bank SRAM front end. A word-addressed space
//               is split across BANK_NUM byte-maskable regfile banks using
//               linear (bank = addr MSBs) or interleaved (bank = addr LSBs)
//               mapping. Two request ports may hit different banks in the same
//               cycle; same-bank collisions are resolved by a one-bit
//               round-robin arbiter using valid/ready back-pressure.
// Ports       : clk_i, rst_n_i (async, active-low)
//               pX_valid_i / pX_ready_o   request handshake (X = 0, 1)
//               pX_wen_i, pX_bm_i         write enable, byte write mask
//               pX_addr_i, pX_wdata_i     word address, write data
//               pX_rvalid_o, pX_rdata_o   read response (one-cycle pulse)
// Options     : `define SRAM_BANK_ARB_OUT_REG_EN adds a registered output stage
//               per port (read latency 2, rdata holds until the next rvalid).
//               Undefined: latency 1, rdata is the bank-output mux.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bank_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int BANK_DEPTH = 512,
   parameter int BANK_NUM   = 4,
   parameter int INTERLEAVE = 0,
   localparam int AW = $clog2(BANK_DEPTH * BANK_NUM),
   localparam int BW = $clog2(BANK_NUM),
   localparam int MW = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   // port 0
   input  logic                  p0_valid_i,
   output logic                  p0_ready_o,
   input  logic                  p0_wen_i,
   input  logic [MW-1:0]         p0_bm_i,
   input  logic [AW-1:0]         p0_addr_i,
   input  logic [DATA_WIDTH-1:0] p0_wdata_i,
   output logic                  p0_rvalid_o,
   output logic [DATA_WIDTH-1:0] p0_rdata_o,
   // port 1
   input  logic                  p1_valid_i,
   output logic                  p1_ready_o,
   input  logic                  p1_wen_i,
   input  logic [MW-1:0]         p1_bm_i,
   input  logic [AW-1:0]         p1_addr_i,
   input  logic [DATA_WIDTH-1:0] p1_wdata_i,
   output logic                  p1_rvalid_o,
   output logic [DATA_WIDTH-1:0] p1_rdata_o
);

   localparam int RW = AW - BW;   // row address width inside one bank

   // ------------------------------------------------------------------------
   // Request gathering: both ports folded into 2-entry vectors
   // ------------------------------------------------------------------------
   logic [1:0]                  req_valid;
   logic [1:0]                  req_wen;
   logic [1:0][MW-1:0]          req_bm;
   logic [1:0][BW-1:0]          req_bank;
   logic [1:0][RW-1:0]          req_row;
   logic [1:0][DATA_WIDTH-1:0]  req_wdata;

   assign req_valid = {p1_valid_i, p0_valid_i};
   assign req_wen   = {p1_wen_i,   p0_wen_i};
   assign req_bm    = {p1_bm_i,    p0_bm_i};
   assign req_wdata = {p1_wdata_i, p0_wdata_i};

   generate
      if (INTERLEAVE == 0) begin : g_linear
         assign req_bank[0] = p0_addr_i[AW-1 -: BW];
         assign req_bank[1] = p1_addr_i[AW-1 -: BW];
         assign req_row[0]  = p0_addr_i[RW-1:0];
         assign req_row[1]  = p1_addr_i[RW-1:0];
      end else begin : g_interleave
         assign req_bank[0] = p0_addr_i[BW-1:0];
         assign req_bank[1] = p1_addr_i[BW-1:0];
         assign req_row[0]  = p0_addr_i[AW-1:BW];
         assign req_row[1]  = p1_addr_i[AW-1:BW];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Arbitration. ready only looks at valid and bank index, never at wen/bm.
   // prio_q names the conflict winner (0 = p0); it toggles on every conflict
   // so the loser always wins the next one.
   // ------------------------------------------------------------------------
   logic       conflict;
   logic [1:0] grant;
   logic       prio_d, prio_q;

   always_comb begin
      conflict = (&req_valid) && (req_bank[0] == req_bank[1]);
      grant    = req_valid;
      prio_d   = prio_q;
      if (conflict) begin
         grant  = prio_q ? 2'b10 : 2'b01;
         prio_d = ~prio_q;
      end
   end

   assign p0_ready_o = grant[0];
   assign p1_ready_o = grant[1];

   // ------------------------------------------------------------------------
   // Bank drive: the arbiter guarantees at most one granted port per bank,
   // so an OR-free priority-less steering is sufficient.
   // ------------------------------------------------------------------------
   logic [BANK_NUM-1:0]                 bank_en;
   logic [BANK_NUM-1:0]                 bank_wen;
   logic [BANK_NUM-1:0][MW-1:0]         bank_bm;
   logic [BANK_NUM-1:0][RW-1:0]         bank_row;
   logic [BANK_NUM-1:0][DATA_WIDTH-1:0] bank_wdata;
   logic [BANK_NUM-1:0][DATA_WIDTH-1:0] bank_dat;

   always_comb begin
      bank_en    = '0;
      bank_wen   = '0;
      bank_bm    = '0;
      bank_row   = '0;
      bank_wdata = '0;
      for (int b = 0; b < BANK_NUM; b++) begin
         for (int p = 0; p < 2; p++) begin
            if (grant[p] && (req_bank[p] == BW'(b))) begin
               bank_en[b]    = 1'b1;
               bank_wen[b]   = req_wen[p];
               bank_bm[b]    = req_bm[p];
               bank_row[b]   = req_row[p];
               bank_wdata[b] = req_wdata[p];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Regfile banks: byte-masked synchronous write, registered read data.
   // Contents are not reset.
   // ------------------------------------------------------------------------
   generate
      for (genvar gb = 0; gb < BANK_NUM; gb++) begin : g_bank
         logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
         logic [DATA_WIDTH-1:0] dat_d, dat_q;

         always_comb begin
            dat_d = dat_q;
            if (bank_en[gb] && !bank_wen[gb]) begin
               dat_d = mem[bank_row[gb]];
            end
         end

         always_ff @(posedge clk_i) begin
            dat_q <= dat_d;
            if (bank_en[gb] && bank_wen[gb]) begin
               for (int i = 0; i < MW; i++) begin
                  if (bank_bm[gb][i]) begin
                     mem[bank_row[gb]][i*8 +: 8] <= bank_wdata[gb][i*8 +: 8];
                  end
               end
            end
         end

         assign bank_dat[gb] = dat_q;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Read response. Each port remembers its own bank index so back-to-back
   // reads on different banks pick up the right bank output.
   // ------------------------------------------------------------------------
   logic [1:0]                 rvalid_d, rvalid_q;
   logic [1:0][BW-1:0]         bidx_d, bidx_q;
   logic [1:0][DATA_WIDTH-1:0] rd_mux;

   always_comb begin
      rvalid_d = '0;
      bidx_d   = bidx_q;
      for (int p = 0; p < 2; p++) begin
         rvalid_d[p] = grant[p] & ~req_wen[p];
         if (grant[p]) begin
            bidx_d[p] = req_bank[p];
         end
         // gated so rdata reads 0 outside of a response
         rd_mux[p] = rvalid_q[p] ? bank_dat[bidx_q[p]] : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         prio_q   <= 1'b0;
         rvalid_q <= '0;
         bidx_q   <= '0;
      end else begin
         prio_q   <= prio_d;
         rvalid_q <= rvalid_d;
         bidx_q   <= bidx_d;
      end
   end

`ifdef SRAM_BANK_ARB_OUT_REG_EN
   // Output stage: rvalid delayed one cycle, rdata captured and held.
   logic [1:0]                 ovalid_d, ovalid_q;
   logic [1:0][DATA_WIDTH-1:0] ordata_d, ordata_q;

   always_comb begin
      ovalid_d = rvalid_q;
      ordata_d = ordata_q;
      for (int p = 0; p < 2; p++) begin
         if (rvalid_q[p]) begin
            ordata_d[p] = rd_mux[p];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ovalid_q <= '0;
         ordata_q <= '0;
      end else begin
         ovalid_q <= ovalid_d;
         ordata_q <= ordata_d;
      end
   end

   assign p0_rvalid_o = ovalid_q[0];
   assign p1_rvalid_o = ovalid_q[1];
   assign p0_rdata_o  = ordata_q[0];
   assign p1_rdata_o  = ordata_q[1];
`else
   assign p0_rvalid_o = rvalid_q[0];
   assign p1_rvalid_o = rvalid_q[1];
   assign p0_rdata_o  = rd_mux[0];
   assign p1_rdata_o  = rd_mux[1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_bank_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_bank_arb
// Description : Directed self-checking bench for sram_bank_arb. Instance A uses
//               linear mapping, instance B interleaved mapping; both share the
//               same request stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bank_arb;

`ifdef SRAM_BANK_ARB_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        p0_valid, p0_wen, p1_valid, p1_wen;
   logic [3:0]  p0_bm, p1_bm;
   logic [10:0] p0_addr, p1_addr;
   logic [31:0] p0_wdata, p1_wdata;

   logic        a_p0_ready, a_p1_ready, a_p0_rvalid, a_p1_rvalid;
   logic [31:0] a_p0_rdata, a_p1_rdata;
   logic        b_p0_ready, b_p1_ready, b_p0_rvalid, b_p1_rvalid;
   logic [31:0] b_p0_rdata, b_p1_rdata;

   int checks = 0;
   int errors = 0;
   int cnt0, cnt1;
   int j;

   sram_bank_arb #(.INTERLEAVE(0)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n),
      .p0_valid_i(p0_valid), .p0_ready_o(a_p0_ready), .p0_wen_i(p0_wen),
      .p0_bm_i(p0_bm), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
      .p0_rvalid_o(a_p0_rvalid), .p0_rdata_o(a_p0_rdata),
      .p1_valid_i(p1_valid), .p1_ready_o(a_p1_ready), .p1_wen_i(p1_wen),
      .p1_bm_i(p1_bm), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
      .p1_rvalid_o(a_p1_rvalid), .p1_rdata_o(a_p1_rdata)
   );

   sram_bank_arb #(.INTERLEAVE(1)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n),
      .p0_valid_i(p0_valid), .p0_ready_o(b_p0_ready), .p0_wen_i(p0_wen),
      .p0_bm_i(p0_bm), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
      .p0_rvalid_o(b_p0_rvalid), .p0_rdata_o(b_p0_rdata),
      .p1_valid_i(p1_valid), .p1_ready_o(b_p1_ready), .p1_wen_i(p1_wen),
      .p1_bm_i(p1_bm), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
      .p1_rvalid_o(b_p1_rvalid), .p1_rdata_o(b_p1_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv0(input logic v, input logic w, input logic [3:0] bm,
                       input logic [10:0] a, input logic [31:0] d);
      p0_valid = v; p0_wen = w; p0_bm = bm; p0_addr = a; p0_wdata = d;
   endtask

   task automatic drv1(input logic v, input logic w, input logic [3:0] bm,
                       input logic [10:0] a, input logic [31:0] d);
      p1_valid = v; p1_wen = w; p1_bm = bm; p1_addr = a; p1_wdata = d;
   endtask

   task automatic idle();
      drv0(1'b0, 1'b0, 4'h0, 11'd0, 32'h0);
      drv1(1'b0, 1'b0, 4'h0, 11'd0, 32'h0);
   endtask

   // reference pattern for the interleaved streaming test
   function automatic logic [31:0] ref_word(input int a);
      return 32'hC0DE_0000 | (a * 32'h0000_0101);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- reset state ----------------
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      chk("rst_ready0",  a_p0_ready,  1'b0);
      chk("rst_ready1",  a_p1_ready,  1'b0);
      chk("rst_rvalid0", a_p0_rvalid, 1'b0);
      chk("rst_rvalid1", a_p1_rvalid, 1'b0);
      chk("rst_rdata0",  a_p0_rdata,  32'h0);
      chk("rst_rdata1",  a_p1_rdata,  32'h0);
      rst_n = 1'b1;
      tick();

      // ---------------- parallel writes, banks 0 and 1 ----------------
      drv0(1'b1, 1'b1, 4'hF, 11'd0,   32'h1000_0001);
      drv1(1'b1, 1'b1, 4'hF, 11'd513, 32'h2000_0002);
      #1;
      chk("wr_ready0", a_p0_ready, 1'b1);
      chk("wr_ready1", a_p1_ready, 1'b1);
      tick();
      drv0(1'b1, 1'b0, 4'hF, 11'd0,   32'h0);
      drv1(1'b1, 1'b0, 4'hF, 11'd513, 32'h0);
      #1;
      chk("rd_ready0", a_p0_ready, 1'b1);
      chk("rd_ready1", a_p1_ready, 1'b1);
      tick();
      idle();
      repeat (LAT - 1) tick();
      chk("rd_rvalid0", a_p0_rvalid, 1'b1);
      chk("rd_rdata0",  a_p0_rdata,  32'h1000_0001);
      chk("rd_rvalid1", a_p1_rvalid, 1'b1);
      chk("rd_rdata1",  a_p1_rdata,  32'h2000_0002);
      tick();
      chk("rd_pulse0", a_p0_rvalid, 1'b0);
      chk("rd_pulse1", a_p1_rvalid, 1'b0);

      // ---------------- same-bank conflict on bank 2 ----------------
      drv0(1'b1, 1'b1, 4'hF, 11'd1024, 32'hAAAA_0000);
      tick();
      idle();
      drv1(1'b1, 1'b1, 4'hF, 11'd1025, 32'hBBBB_0001);
      tick();
      cnt0 = 0;
      cnt1 = 0;
      drv0(1'b1, 1'b0, 4'hF, 11'd1024, 32'h0);
      drv1(1'b1, 1'b0, 4'hF, 11'd1025, 32'h0);
      for (int k = 0; k < 4 + LAT; k++) begin
         if (k == 4) idle();
         #1;
         if (k < 4) begin
            chk("conf_ready0", a_p0_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
            chk("conf_ready1", a_p1_ready, (k % 2 == 1) ? 1'b1 : 1'b0);
         end
         tick();
         if (a_p0_rvalid) begin
            cnt0++;
            chk("conf_rdata0", a_p0_rdata, 32'hAAAA_0000);
         end
         if (a_p1_rvalid) begin
            cnt1++;
            chk("conf_rdata1", a_p1_rdata, 32'hBBBB_0001);
         end
      end
      chk("conf_cnt0", cnt0, 2);
      chk("conf_cnt1", cnt1, 2);
      // four conflicts -> priority back on p0
      drv0(1'b1, 1'b0, 4'hF, 11'd1024, 32'h0);
      drv1(1'b1, 1'b0, 4'hF, 11'd1025, 32'h0);
      #1;
      chk("prio_ready0", a_p0_ready, 1'b1);
      chk("prio_ready1", a_p1_ready, 1'b0);
      tick();  // p0 wins, priority now on p1
      idle();
      repeat (LAT + 1) tick();

      // ---------------- byte mask ----------------
      drv0(1'b1, 1'b1, 4'hF, 11'd7,    32'hFFFF_FFFF);
      drv1(1'b1, 1'b1, 4'hF, 11'd1536, 32'h3333_0003);
      tick();
      idle();
      drv0(1'b1, 1'b1, 4'b0101, 11'd7, 32'h0000_0000);
      tick();
      drv0(1'b1, 1'b0, 4'hF, 11'd7, 32'h0);
      tick();
      idle();
      repeat (LAT - 1) tick();
      chk("bm_rvalid", a_p0_rvalid, 1'b1);
      chk("bm_rdata",  a_p0_rdata,  32'hFF00_FF00);
      tick();

      // ---------------- back-to-back reads bank 0 then bank 3 ----------------
      drv0(1'b1, 1'b0, 4'hF, 11'd0, 32'h0);
      for (int s = 0; s < 4; s++) begin
         tick();
         chk("b2b_rvalid", a_p0_rvalid, ((s == LAT - 1) || (s == LAT)) ? 1'b1 : 1'b0);
         if (s == LAT - 1) chk("b2b_rdata_b0", a_p0_rdata, 32'h1000_0001);
         if (s == LAT)     chk("b2b_rdata_b3", a_p0_rdata, 32'h3333_0003);
         if (s == 0) drv0(1'b1, 1'b0, 4'hF, 11'd1536, 32'h0);
         if (s == 1) idle();
      end

      // ---------------- reset between acceptance and rvalid ----------------
      drv0(1'b1, 1'b0, 4'hF, 11'd0, 32'h0);
      tick();
      idle();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rvalid", a_p0_rvalid, 1'b0);
      chk("mid_rst_rdata",  a_p0_rdata,  32'h0);
      tick();
      rst_n = 1'b1;
      chk("post_rst_rvalid", a_p0_rvalid, 1'b0);
      tick();
      chk("post_rst_rvalid2", a_p0_rvalid, 1'b0);
      // priority was on p1 before reset; reset must return it to p0
      drv0(1'b1, 1'b0, 4'hF, 11'd1024, 32'h0);
      drv1(1'b1, 1'b0, 4'hF, 11'd1025, 32'h0);
      #1;
      chk("rst_prio_ready0", a_p0_ready, 1'b1);
      chk("rst_prio_ready1", a_p1_ready, 1'b0);
      tick();
      idle();
      repeat (LAT + 1) tick();

      // ---------------- interleaved streaming (instance B) ----------------
      for (int k = 0; k < 4; k++) begin
         drv0(1'b1, 1'b1, 4'hF, 11'(2 * k),     ref_word(2 * k));
         drv1(1'b1, 1'b1, 4'hF, 11'(2 * k + 1), ref_word(2 * k + 1));
         #1;
         chk("ilv_wr_ready0", b_p0_ready, 1'b1);
         chk("ilv_wr_ready1", b_p1_ready, 1'b1);
         tick();
      end
      idle();
      for (int s = 0; s < 4 + LAT; s++) begin
         if (s < 4) begin
            drv0(1'b1, 1'b0, 4'hF, 11'(2 * s),     32'h0);
            drv1(1'b1, 1'b0, 4'hF, 11'(2 * s + 1), 32'h0);
         end else begin
            idle();
         end
         #1;
         if (s < 4) begin
            chk("ilv_rd_ready0", b_p0_ready, 1'b1);
            chk("ilv_rd_ready1", b_p1_ready, 1'b1);
         end
         tick();
         j = s - (LAT - 1);
         if (j >= 0 && j < 4) begin
            chk("ilv_rvalid0", b_p0_rvalid, 1'b1);
            chk("ilv_rdata0",  b_p0_rdata,  ref_word(2 * j));
            chk("ilv_rvalid1", b_p1_rvalid, 1'b1);
            chk("ilv_rdata1",  b_p1_rdata,  ref_word(2 * j + 1));
         end
      end
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
